pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_pkg.sv | 18 +
 rtl/pc_ret_stack.sv | 78 +++++++
 rtl/pc_sequencer.sv | 134 +++++++++++++
 tb/tb_pc_sequencer.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/pc_pkg.sv
// Shared encodings for the program-counter sequencer: opcodes and FSM states.
package pc_pkg;

    typedef enum logic [2:0] {
        OP_NEXT   = 3'd0,
        OP_JUMP   = 3'd1,
        OP_BRANCH = 3'd2,
        OP_CALL   = 3'd3,
        OP_RET    = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_e;

endpackage

// File: rtl/pc_ret_stack.sv
// Return-address stack. Only the pointer is reset; storage keeps stale data.
// Push on full and pop on empty are ignored here; the sequencer also prevents them.
module pc_ret_stack #(
    parameter int PC_BITS     = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_push,
    input  logic               i_pop,
    input  logic [PC_BITS-1:0] i_data,
    output logic [PC_BITS-1:0] o_top,
    output logic               o_full,
    output logic               o_empty
);

    localparam int PTR_W = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(STACK_DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [PC_BITS-1:0] mem_q [STACK_DEPTH];
    logic [PTR_W-1:0]   ptr_q;
    logic [PTR_W-1:0]   ptr_d;
    logic [PTR_W-1:0]   top_ptr_s;
    logic [IDX_W-1:0]   top_idx_s;
    logic [IDX_W-1:0]   wr_idx_s;
    logic               full_q;
    logic               empty_q;
    logic               do_push_s;
    logic               do_pop_s;

    // Next pointer and read/write indices; top index is parked at 0 when empty.
    always_comb begin
        do_push_s = i_push && !full_q;
        do_pop_s  = i_pop && !empty_q && !i_push;
        ptr_d     = ptr_q;
        if (do_push_s) begin
            ptr_d = ptr_q + PTR_ONE;
        end else if (do_pop_s) begin
            ptr_d = ptr_q - PTR_ONE;
        end else begin
            ptr_d = ptr_q;
        end
        if (empty_q) begin
            top_ptr_s = '0;
        end else begin
            top_ptr_s = ptr_q - PTR_ONE;
        end
        top_idx_s = top_ptr_s[IDX_W-1:0];
        wr_idx_s  = ptr_q[IDX_W-1:0];
    end

    // Storage write; intentionally not reset.
    always_ff @(posedge i_clk) begin
        if (do_push_s) begin
            mem_q[wr_idx_s] <= i_data;
        end
    end

    // Pointer and registered occupancy flags.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            ptr_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            ptr_q   <= ptr_d;
            full_q  <= (ptr_d == DEPTH_P);
            empty_q <= (ptr_d == '0);
        end
    end

    assign o_top   = mem_q[top_idx_s];
    assign o_full  = full_q;
    assign o_empty = empty_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: NEXT/JUMP/BRANCH/CALL/RET with a return stack.
// BOOT lasts one cycle after reset; stack misuse locks into FAULT until reset.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int                 PC_BITS      = 8,
    parameter int                 STACK_DEPTH  = 4,
    parameter logic [PC_BITS-1:0] RESET_VECTOR = '0
) (
    input  logic               i_clk,
    input  logic               i_nrst,
    input  logic               i_en,
    input  logic [2:0]         i_op,
    input  logic [PC_BITS-1:0] i_target,
    input  logic [PC_BITS-1:0] i_offset,
    input  logic               i_cond,
    output logic [PC_BITS-1:0] o_pc,
    output logic               o_valid,
    output logic               o_stack_full,
    output logic               o_stack_empty,
    output logic               o_fault
);

    localparam logic [PC_BITS-1:0] PC_ONE = PC_BITS'(1);

    state_e             state_q;
    state_e             state_d;
    logic [PC_BITS-1:0] pc_q;
    logic [PC_BITS-1:0] pc_d;
    logic [PC_BITS-1:0] pc_inc_s;
    logic [PC_BITS-1:0] top_s;
    logic               valid_q;
    logic               fault_q;
    logic               push_s;
    logic               pop_s;
    logic               full_s;
    logic               empty_s;

    pc_ret_stack #(
        .PC_BITS     (PC_BITS),
        .STACK_DEPTH (STACK_DEPTH)
    ) u_stack (
        .i_clk   (i_clk),
        .i_nrst  (i_nrst),
        .i_push  (push_s),
        .i_pop   (pop_s),
        .i_data  (pc_inc_s),
        .o_top   (top_s),
        .o_full  (full_s),
        .o_empty (empty_s)
    );

    // Next-state, next-PC and stack control; misuse faults without side effects.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        push_s   = 1'b0;
        pop_s    = 1'b0;
        pc_inc_s = pc_q + PC_ONE;
        case (state_q)
            ST_BOOT: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (i_en) begin
                    case (i_op)
                        OP_NEXT: begin
                            pc_d = pc_inc_s;
                        end
                        OP_JUMP: begin
                            pc_d = i_target;
                        end
                        OP_BRANCH: begin
                            if (i_cond) begin
                                pc_d = pc_q + i_offset;
                            end else begin
                                pc_d = pc_inc_s;
                            end
                        end
                        OP_CALL: begin
                            if (full_s) begin
                                state_d = ST_FAULT;
                            end else begin
                                push_s = 1'b1;
                                pc_d   = i_target;
                            end
                        end
                        OP_RET: begin
                            if (empty_s) begin
                                state_d = ST_FAULT;
                            end else begin
                                pop_s = 1'b1;
                                pc_d  = top_s;
                            end
                        end
                        default: begin
                            pc_d = pc_q;
                        end
                    endcase
                end else begin
                    pc_d = pc_q;
                end
            end
            ST_FAULT: begin
                state_d = ST_FAULT;
            end
            default: begin
                state_d = ST_FAULT;
            end
        endcase
    end

    // State, PC and status flag registers.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            state_q <= ST_BOOT;
            pc_q    <= RESET_VECTOR;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            valid_q <= (state_d == ST_RUN);
            fault_q <= (state_d == ST_FAULT);
        end
    end

    assign o_pc          = pc_q;
    assign o_valid       = valid_q;
    assign o_fault       = fault_q;
    assign o_stack_full  = full_s;
    assign o_stack_empty = empty_s;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (PC_BITS=8, STACK_DEPTH=4, RESET_VECTOR=0x10).
module tb_pc_sequencer;

    logic       clk;
    logic       nrst;
    logic       en;
    logic [2:0] op;
    logic [7:0] target;
    logic [7:0] offset;
    logic       cond;
    logic [7:0] pc;
    logic       valid;
    logic       full;
    logic       empty;
    logic       fault;

    int checks;
    int failures;

    localparam logic [2:0] NEXT   = 3'd0;
    localparam logic [2:0] JUMP   = 3'd1;
    localparam logic [2:0] BRANCH = 3'd2;
    localparam logic [2:0] CALL   = 3'd3;
    localparam logic [2:0] RET    = 3'd4;

    pc_sequencer #(
        .PC_BITS      (8),
        .STACK_DEPTH  (4),
        .RESET_VECTOR (8'h10)
    ) dut (
        .i_clk         (clk),
        .i_nrst        (nrst),
        .i_en          (en),
        .i_op          (op),
        .i_target      (target),
        .i_offset      (offset),
        .i_cond        (cond),
        .o_pc          (pc),
        .o_valid       (valid),
        .o_stack_full  (full),
        .o_stack_empty (empty),
        .o_fault       (fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Apply one op, let one rising edge pass, return 1 time unit after it.
    task automatic do_op(input logic e, input logic [2:0] o, input logic [7:0] t,
                         input logic [7:0] off, input logic c);
        en     = e;
        op     = o;
        target = t;
        offset = off;
        cond   = c;
        @(posedge clk);
        #1;
    endtask

    // Reset pulse between clock edges, then BOOT cycle, ending in RUN.
    task automatic pulse_reset(input string tag);
        #2 nrst = 1'b0;
        #1;
        chk({tag, "_rst_pc"}, 32'(pc), 32'h10);
        chk({tag, "_rst_valid"}, 32'(valid), 32'h0);
        chk({tag, "_rst_fault"}, 32'(fault), 32'h0);
        chk({tag, "_rst_empty"}, 32'(empty), 32'h1);
        chk({tag, "_rst_full"}, 32'(full), 32'h0);
        // Op presented during BOOT must be ignored.
        en     = 1'b1;
        op     = JUMP;
        target = 8'h55;
        #2 nrst = 1'b1;
        #1;
        chk({tag, "_boot_valid"}, 32'(valid), 32'h0);
        chk({tag, "_boot_pc"}, 32'(pc), 32'h10);
        @(posedge clk);
        #1;
        chk({tag, "_run_valid"}, 32'(valid), 32'h1);
        chk({tag, "_run_pc"}, 32'(pc), 32'h10);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        nrst     = 1'b0;
        en       = 1'b0;
        op       = NEXT;
        target   = 8'h00;
        offset   = 8'h00;
        cond     = 1'b0;

        @(posedge clk);
        #1;
        pulse_reset("init");

        // NEXT, JUMP, wrap
        do_op(1'b1, NEXT, 8'h00, 8'h00, 1'b0);
        chk("next", 32'(pc), 32'h11);
        do_op(1'b1, JUMP, 8'hFF, 8'h00, 1'b0);
        chk("jump_ff", 32'(pc), 32'hFF);
        do_op(1'b1, NEXT, 8'h00, 8'h00, 1'b0);
        chk("next_wrap", 32'(pc), 32'h00);

        // BRANCH taken (negative offset) and not taken
        do_op(1'b1, JUMP, 8'h20, 8'h00, 1'b0);
        do_op(1'b1, BRANCH, 8'h00, 8'hFC, 1'b1);
        chk("branch_taken", 32'(pc), 32'h1C);
        do_op(1'b1, JUMP, 8'h20, 8'h00, 1'b0);
        do_op(1'b1, BRANCH, 8'h00, 8'hFC, 1'b0);
        chk("branch_not", 32'(pc), 32'h21);

        // Reserved opcodes and i_en=0 hold
        do_op(1'b1, 3'd5, 8'h99, 8'h00, 1'b0);
        chk("op5_hold", 32'(pc), 32'h21);
        do_op(1'b1, 3'd7, 8'h99, 8'h00, 1'b0);
        chk("op7_hold", 32'(pc), 32'h21);
        for (int i = 0; i < 3; i++) begin
            do_op(1'b0, JUMP, 8'h99, 8'h00, 1'b0);
            chk("en0_hold", 32'(pc), 32'h21);
        end
        chk("en0_valid", 32'(valid), 32'h1);

        // CALL / RET nesting
        do_op(1'b1, JUMP, 8'h05, 8'h00, 1'b0);
        do_op(1'b1, CALL, 8'h40, 8'h00, 1'b0);
        chk("call1_pc", 32'(pc), 32'h40);
        chk("call1_empty", 32'(empty), 32'h0);
        do_op(1'b1, CALL, 8'h80, 8'h00, 1'b0);
        chk("call2_pc", 32'(pc), 32'h80);
        do_op(1'b1, RET, 8'h00, 8'h00, 1'b0);
        chk("ret1_pc", 32'(pc), 32'h41);
        do_op(1'b1, RET, 8'h00, 8'h00, 1'b0);
        chk("ret2_pc", 32'(pc), 32'h06);
        chk("ret2_empty", 32'(empty), 32'h1);

        // Mid-run asynchronous reset
        do_op(1'b1, JUMP, 8'h77, 8'h00, 1'b0);
        chk("pre_reset_pc", 32'(pc), 32'h77);
        pulse_reset("mid");

        // Overflow: four CALLs fill, the fifth faults
        do_op(1'b1, JUMP, 8'h00, 8'h00, 1'b0);
        do_op(1'b1, CALL, 8'h10, 8'h00, 1'b0);
        do_op(1'b1, CALL, 8'h20, 8'h00, 1'b0);
        do_op(1'b1, CALL, 8'h30, 8'h00, 1'b0);
        chk("call3_full", 32'(full), 32'h0);
        do_op(1'b1, CALL, 8'h40, 8'h00, 1'b0);
        chk("call4_pc", 32'(pc), 32'h40);
        chk("call4_full", 32'(full), 32'h1);
        chk("call4_fault", 32'(fault), 32'h0);
        do_op(1'b1, CALL, 8'h50, 8'h00, 1'b0);
        chk("ovf_fault", 32'(fault), 32'h1);
        chk("ovf_valid", 32'(valid), 32'h0);
        chk("ovf_pc", 32'(pc), 32'h40);
        chk("ovf_full", 32'(full), 32'h1);
        do_op(1'b1, RET, 8'h00, 8'h00, 1'b0);
        chk("fault_ret_pc", 32'(pc), 32'h40);
        chk("fault_ret_fault", 32'(fault), 32'h1);
        chk("fault_ret_full", 32'(full), 32'h1);
        pulse_reset("ovf");

        // Underflow: RET on empty stack faults
        do_op(1'b1, RET, 8'h00, 8'h00, 1'b0);
        chk("unf_fault", 32'(fault), 32'h1);
        chk("unf_valid", 32'(valid), 32'h0);
        chk("unf_pc", 32'(pc), 32'h10);
        do_op(1'b1, JUMP, 8'h33, 8'h00, 1'b0);
        chk("unf_jump_ignored", 32'(pc), 32'h10);
        pulse_reset("unf");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
